// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and address/one-hot types.
package cpu_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]       reg_onehot_t;

    localparam reg_addr_t   ZERO_REG  = 5'd0;
    localparam reg_onehot_t ZERO_MASK = 32'hFFFF_FFFE;

    typedef struct packed {
        logic      en;
        reg_addr_t addr;
    } reg_req_t;

endpackage

// File: rtl/decoder1to32.sv
// 5-bit address plus enable to a 32-bit one-hot strobe vector.
module decoder1to32
    import cpu_pkg::*;
(
    input  logic        en,
    input  reg_addr_t   addr,
    output reg_onehot_t onehot
);

    always_comb begin
        onehot = '0;
        if (en)
            onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_32x32.sv
// 32-entry register file, r0 hardwired to zero, 1W/2R with optional
// write-to-read bypass and a pending-load scoreboard for decode stalls.
module regfile_32x32
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [4:0]            write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_addr1,
    input  logic [4:0]            read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  pend_set_en,
    input  logic [4:0]            pend_set_addr,
    output logic                  pending1,
    output logic                  pending2
);

    reg_req_t    wr_req;
    reg_req_t    set_req;
    reg_onehot_t wr_oh;
    reg_onehot_t set_oh;
    reg_onehot_t wr_mask;
    reg_onehot_t set_mask;

    assign wr_req  = '{en: write_en, addr: write_addr};
    assign set_req = '{en: pend_set_en, addr: pend_set_addr};

    decoder1to32 u_wr_dec (
        .en     (wr_req.en),
        .addr   (wr_req.addr),
        .onehot (wr_oh)
    );

    decoder1to32 u_set_dec (
        .en     (set_req.en),
        .addr   (set_req.addr),
        .onehot (set_oh)
    );

    assign wr_mask  = wr_oh & ZERO_MASK;
    assign set_mask = set_oh & ZERO_MASK;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (wr_mask[i])
                    regs[i] <= write_data;
        end
    end

    // Set after clear: a load issued in the writeback cycle keeps the bit.
    reg_onehot_t pend_q;
    reg_onehot_t pend_d;

    assign pend_d = ((pend_q & ~wr_mask) | set_mask) & ZERO_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    logic [DATA_WIDTH-1:0] rd_arr [NUM_REGS];

    always_comb begin
        rd_arr[0] = '0;
        for (int i = 1; i < NUM_REGS; i++)
            rd_arr[i] = regs[i];
    end

    // Forwarding is gated by reset so outputs read zero while it is held.
    logic wr_live;
    logic byp1;
    logic byp2;

    assign wr_live = (BYPASS != 0) && reset_n && write_en
                     && (write_addr != ZERO_REG);
    assign byp1    = wr_live && (write_addr == read_addr1);
    assign byp2    = wr_live && (write_addr == read_addr2);

    assign read_data1 = byp1 ? write_data : rd_arr[read_addr1];
    assign read_data2 = byp2 ? write_data : rd_arr[read_addr2];

    assign pending1 = !byp1 && pend_q[read_addr1];
    assign pending2 = !byp2 && pend_q[read_addr2];

endmodule

// File: tb/tb_regfile_32x32.sv
// Scoreboard bench for regfile_32x32.
// BYPASS=0 and BYPASS=1 side by side.
module tb_regfile_32x32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic        pend_set_en;
  logic [4:0]  pend_set_addr;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_p1, a_p2, b_p1, b_p2;

  bit done = 1'b0;

  always #5 clk = ~clk;

  regfile_32x32 #(.DATA_WIDTH(32), .BYPASS(0)) dut_nb (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_addr1    (read_addr1),
    .read_addr2    (read_addr2),
    .read_data1    (a_rd1),
    .read_data2    (a_rd2),
    .pend_set_en   (pend_set_en),
    .pend_set_addr (pend_set_addr),
    .pending1      (a_p1),
    .pending2      (a_p2)
  );

  regfile_32x32 #(.DATA_WIDTH(32), .BYPASS(1)) dut_by (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .read_addr1    (read_addr1),
    .read_addr2    (read_addr2),
    .read_data1    (b_rd1),
    .read_data2    (b_rd2),
    .pend_set_en   (pend_set_en),
    .pend_set_addr (pend_set_addr),
    .pending1      (b_p1),
    .pending2      (b_p2)
  );

  typedef struct {
    int          tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   seq    = 0;

  function automatic logic [31:0] actual(int kind);
    case (kind)
      0: return a_rd1;
      1: return a_rd2;
      2: return {31'd0, a_p1};
      3: return {31'd0, a_p2};
      4: return b_rd1;
      5: return b_rd2;
      6: return {31'd0, b_p1};
      default: return {31'd0, b_p2};
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0: return "nobyp.rd1";
      1: return "nobyp.rd2";
      2: return "nobyp.pend1";
      3: return "nobyp.pend2";
      4: return "byp.rd1";
      5: return "byp.rd2";
      6: return "byp.pend1";
      default: return "byp.pend2";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = actual(e.kind);
      n_chk++;
      if (act === e.val)
        n_pass++;
      else
        $display("FAIL #%0d %s got %h want %h",
                 e.tag, kname(e.kind), act, e.val);
    end
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL timeout: stimulus did not finish");
      $finish;
    end
  end

  task automatic push(int kind, logic [31:0] v);
    exp_t e;
    e.tag  = seq;
    e.kind = kind;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic ex(int d, logic [31:0] r1,
                    logic [31:0] r2,
                    logic q1, logic q2);
    push(d * 4 + 0, r1);
    push(d * 4 + 1, r2);
    push(d * 4 + 2, {31'd0, q1});
    push(d * 4 + 3, {31'd0, q2});
  endtask

  task automatic drive(logic rst, logic we,
                       logic [4:0] wa,
                       logic [31:0] wd,
                       logic [4:0] r1,
                       logic [4:0] r2,
                       logic ps,
                       logic [4:0] psa);
    @(posedge clk);
    #1;
    seq++;
    reset_n       = rst;
    write_en      = we;
    write_addr    = wa;
    write_data    = wd;
    read_addr1    = r1;
    read_addr2    = r2;
    pend_set_en   = ps;
    pend_set_addr = psa;
  endtask

  initial begin
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] v;
    reset_n = 1'b0; write_en = 1'b0;
    write_addr = '0; write_data = '0;
    read_addr1 = '0; read_addr2 = '0;
    pend_set_en = 1'b0; pend_set_addr = '0;

    drive(0, 1, 3, 32'h0000AAAA, 3, 3, 1, 3);
    ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0);
    #1;
    n_chk++;
    if ({a_rd1, a_rd2, b_rd1, b_rd2} === '0 &&
        {a_p1, a_p2, b_p1, b_p2} === 4'b0)
      n_pass++;
    else
      $display("FAIL reset state: %h %h %h %h %b%b%b%b",
               a_rd1, a_rd2, b_rd1, b_rd2,
               a_p1, a_p2, b_p1, b_p2);

    drive(1, 1, 5, 32'hDEADBEEF, 5, 3, 0, 0);
    ex(0, 0, 0, 0, 0); ex(1, 32'hDEADBEEF, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 3, 0, 0);
    ex(0, 32'hDEADBEEF, 0, 0, 0);
    ex(1, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 3, 0, 0);
    ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0);

    drive(1, 1, 7, 32'h12345678, 7, 7, 0, 0);
    ex(0, 0, 0, 0, 0);
    ex(1, 32'h12345678, 32'h12345678, 0, 0);
    drive(1, 0, 0, 0, 7, 7, 0, 0);
    ex(0, 32'h12345678, 32'h12345678, 0, 0);
    ex(1, 32'h12345678, 32'h12345678, 0, 0);

    drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0); ex(1, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 9, 7, 1, 9);
    ex(0, 0, 32'h12345678, 0, 0);
    ex(1, 0, 32'h12345678, 0, 0);
    drive(1, 0, 0, 0, 9, 7, 0, 0);
    ex(0, 0, 32'h12345678, 1, 0);
    ex(1, 0, 32'h12345678, 1, 0);
    drive(1, 1, 9, 32'h55, 9, 7, 0, 0);
    ex(0, 0, 32'h12345678, 1, 0);
    ex(1, 32'h55, 32'h12345678, 0, 0);
    drive(1, 0, 0, 0, 9, 7, 0, 0);
    ex(0, 32'h55, 32'h12345678, 0, 0);
    ex(1, 32'h55, 32'h12345678, 0, 0);
    drive(1, 1, 9, 32'h66, 9, 7, 1, 9);
    ex(0, 32'h55, 32'h12345678, 0, 0);
    ex(1, 32'h66, 32'h12345678, 0, 0);
    drive(1, 0, 0, 0, 9, 7, 0, 0);
    ex(0, 32'h66, 32'h12345678, 1, 0);
    ex(1, 32'h66, 32'h12345678, 1, 0);
    drive(1, 1, 9, 32'h77, 9, 10, 1, 10);
    ex(0, 32'h66, 0, 1, 0); ex(1, 32'h77, 0, 0, 0);
    drive(1, 0, 0, 0, 9, 10, 0, 0);
    ex(0, 32'h77, 0, 0, 1); ex(1, 32'h77, 0, 0, 1);
    drive(1, 0, 7, 32'h00000BAD, 0, 7, 1, 0);
    ex(0, 0, 32'h12345678, 0, 0);
    ex(1, 0, 32'h12345678, 0, 0);
    drive(1, 0, 0, 0, 0, 7, 0, 0);
    ex(0, 0, 32'h12345678, 0, 0);
    ex(1, 0, 32'h12345678, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 1; a < 32; a++) begin
      v = a * 32'h01010101;
      drive(1, 1, 5'(a), v, 5'(a), 0, 0, 0);
      ex(0, 0, 0, 0, 0); ex(1, v, 0, 0, 0);
    end
    for (int i = 0; i < 32; i++) begin
      r1 = 5'((i * 7 + 3) % 32);
      r2 = 5'((i * 13 + 5) % 32);
      drive(1, 0, 0, 0, r1, r2, 0, 0);
      ex(0, r1 * 32'h01010101, r2 * 32'h01010101, 0, 0);
      ex(1, r1 * 32'h01010101, r2 * 32'h01010101, 0, 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    if (n_pass == n_chk && n_chk > 0)
      $display("PASS %0d/%0d checks passed", n_pass, n_chk);
    else
      $display("FAIL %0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- Register storage that feeds the CPU's 32:1 read multiplexers. Sits between writeback (upstream) and the two operand read ports (downstream).
- Holds 32 words with register 0 hardwired to zero, one synchronous write port and two combinational read ports.
- Includes optional write-to-read bypass.
- Includes a per-register pending-load scoreboard so the decode stage can stall on read-after-load hazards.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = the read returns the old stored value.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write strobe for the write port.
- write_addr  input  5  destination register.
- write_data  input  DATA_WIDTH  value to write.
- read_addr1  input  5  read port 1 address.
- read_addr2  input  5  read port 2 address.
- read_data1  output  DATA_WIDTH  read port 1 data.
- read_data2  output  DATA_WIDTH  read port 2 data.
- pend_set_en  input  1  a load has issued; mark pend_set_addr as pending.
- pend_set_addr  input  5  register the issued load targets.
- pending1  output  1  read_addr1 is awaiting a load writeback.
- pending2  output  1  read_addr2 is awaiting a load writeback.

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low.
- On reset_n=0:
  - all 31 storage registers clear to 0 immediately, without waiting for a clock edge;
  - all pending bits clear.
  - While reset is held, read_data1/2 = 0 and pending1/2 = 0.
- Write:
  - On a rising clk edge with write_en=1 and write_addr!=0, reg[write_addr] <= write_data.
  - Writes to address 0 are discarded.
  - Write latency is 1 cycle: the value is visible in storage from the next cycle.
- Read:
  - Combinational, zero latency.
  - Address 0 always returns 0, including when a bypass would otherwise apply.
  - When BYPASS=1, write_en=1, write_addr==read_addrN and write_addr!=0, read_dataN = write_data in the same cycle.
  - Otherwise read_dataN = reg[read_addrN].
  - Both read ports may address the same register; both return the same value.
- Scoreboard (31 pending bits, index 0 constant 0):
  - A write to address A clears pending[A] at the clock edge.
  - pend_set_en sets pending[pend_set_addr] at the clock edge.
  - A set to address 0 is ignored.
  - If a set and a clear hit the same address in the same cycle, the set wins and the bit ends at 1 (a new load has been issued).
  - If they hit different addresses, both take effect.
  - pendingN = pending[read_addrN], combinational.
  - When BYPASS=1 and the same-cycle write clears read_addrN, pendingN = 0 in that cycle, consistent with the bypassed data.
- Reset mid-operation: any in-flight write or set is lost; state returns to all-zero.
- X-safety: write_en=0 leaves all storage unchanged regardless of address or data values.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_WIDTH = 5
  - NUM_REGS = 32
  - ZERO_REG = 5'd0
- One natural sub-module: decoder1to32, a 5-bit address plus enable to a 32-bit one-hot vector. It is used for the write enables and for the pending set/clear enables.
- Read selection reuses the existing 32-to-1 by 32 multiplexer, driven from a storage array whose entry 0 is tied to 0.

Test Plan:
- Reset clears storage: write 0xDEADBEEF to r5, then pulse reset_n low mid-cycle -> read_data1 of r5 = 0 immediately, with no clock edge needed.
- Write/read, BYPASS=0: write 0x12345678 to r7 with read_addr1=7 -> old value 0 in the write cycle, 0x12345678 from the next cycle.
- Bypass, BYPASS=1: same stimulus -> read_data1 = 0x12345678 in the write cycle; both ports on r7 match.
- Zero register: write 0xFFFFFFFF to r0 with read_addr1=read_addr2=0 -> both read 0 in that cycle and after, for both BYPASS values.
- Scoreboard: pend_set r9 -> pending1 = 1 next cycle; write r9 -> pending1 = 0; set r9 and write r9 in the same cycle -> pending1 stays 1 and data is updated.
- Sweep: write r1..r31 with value (addr×0x01010101), read back on both ports at random addresses -> all match, with no aliasing between registers.
